// File: rtl/cache_arbiter_if.sv
// Cache-line bus joining the I-cache, D-cache, the arbiter and physical memory.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface cache_arbiter_if;
  // Handshake: a cache holds x_read/x_write with a stable address and wdata
  // until x_resp. x_resp is a single-cycle pulse and x_rdata is non-zero only
  // while it is high. pmem_read/pmem_write are held until the one-cycle
  // pmem_resp. The cache must drop its request after seeing x_resp, or it is
  // granted again.
  logic         icache_read;
  logic         icache_write;
  logic [15:0]  icache_address;
  logic [127:0] icache_wdata;
  logic [127:0] icache_rdata;
  logic         icache_resp;

  logic         dcache_read;
  logic         dcache_write;
  logic [15:0]  dcache_address;
  logic [127:0] dcache_wdata;
  logic [127:0] dcache_rdata;
  logic         dcache_resp;

  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic [1:0]   dbg_state;

  modport slave (
    input  icache_read, icache_write, icache_address, icache_wdata,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output dbg_state
  );

  modport master (
    output icache_read, icache_write, icache_address, icache_wdata,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  dbg_state
  );
endinterface

// File: rtl/cache_arbiter.sv
// Serializes I-cache and D-cache line requests onto one physical-memory port,
// alternating between the caches when both are waiting.
module cache_arbiter (
  input  logic           clk,
  input  logic           reset,
  cache_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  logic [1:0]   state_q, state_d;
  logic         last_served_q, last_served_d;
  logic [15:0]  req_addr_q, req_addr_d;
  logic [127:0] req_wdata_q, req_wdata_d;
  logic         req_is_write_q, req_is_write_d;

  logic i_req;
  logic d_req;
  logic grant_d;
  logic busy;
  logic i_done;
  logic d_done;

  always_comb begin
    i_req   = bus.icache_read | bus.icache_write;
    d_req   = bus.dcache_read | bus.dcache_write;
    // A tie goes to whichever port was not served last.
    grant_d = d_req & (~i_req | (last_served_q == PORT_I));
  end

  always_comb begin
    state_d        = state_q;
    last_served_d  = last_served_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_is_write_d = req_is_write_q;
    case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          if (grant_d) begin
            state_d        = BUSY_D;
            last_served_d  = PORT_D;
            req_addr_d     = bus.dcache_address;
            req_wdata_d    = bus.dcache_wdata;
            // read+write together is resolved as a write
            req_is_write_d = bus.dcache_write;
          end else begin
            state_d        = BUSY_I;
            last_served_d  = PORT_I;
            req_addr_d     = bus.icache_address;
            req_wdata_d    = bus.icache_wdata;
            req_is_write_d = bus.icache_write;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_served_q  <= PORT_I;
      req_addr_q     <= 16'h0000;
      req_wdata_q    <= 128'h0;
      req_is_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_served_q  <= last_served_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_is_write_q <= req_is_write_d;
    end
  end

  // Completion is combinational from pmem_resp; reset overrides it.
  always_comb begin
    busy   = (state_q == BUSY_I) | (state_q == BUSY_D);
    i_done = (state_q == BUSY_I) & bus.pmem_resp & ~reset;
    d_done = (state_q == BUSY_D) & bus.pmem_resp & ~reset;
  end

  assign bus.pmem_read    = busy & ~req_is_write_q;
  assign bus.pmem_write   = busy &  req_is_write_q;
  assign bus.pmem_address = req_addr_q;
  assign bus.pmem_wdata   = req_wdata_q;

  assign bus.icache_resp  = i_done;
  assign bus.icache_rdata = i_done ? bus.pmem_rdata : 128'h0;
  assign bus.dcache_resp  = d_done;
  assign bus.dcache_rdata = d_done ? bus.pmem_rdata : 128'h0;

  assign bus.dbg_state    = state_q;

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(bus.pmem_read && bus.pmem_write));

  a_resp_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(bus.icache_resp && bus.dcache_resp));

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios then randomized cache/memory
// traffic, every cycle compared with a transaction-level reference model.
module tb_cache_arbiter;

  logic clk = 1'b0;
  logic reset;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: who owns memory (-1 none, 0 I, 1 D), who was served last,
  // and the transaction that was captured at grant time.
  int           m_owner;
  int           m_last;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  logic         m_wr;

  logic seen_iresp, seen_dresp, seen_strobe;
  logic [127:0] i_exp_q[$];
  logic [127:0] d_exp_q[$];
  int mem_wait;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_addr  = '0;
    m_wdata = '0;
    m_wr    = 1'b0;
  endtask

  task automatic compare_model();
    logic e_rd, e_wr, e_iresp, e_dresp;
    e_rd    = (m_owner >= 0) && !m_wr;
    e_wr    = (m_owner >= 0) && m_wr;
    e_iresp = (m_owner == 0) && bus.pmem_resp;
    e_dresp = (m_owner == 1) && bus.pmem_resp;
    chk("pmem_read", bus.pmem_read, e_rd);
    chk("pmem_write", bus.pmem_write, e_wr);
    if (m_owner >= 0) begin
      chk("pmem_address", bus.pmem_address, m_addr);
      chk("pmem_wdata", bus.pmem_wdata, m_wdata);
    end
    if (!reset) begin
      chk("icache_resp", bus.icache_resp, e_iresp);
      chk("dcache_resp", bus.dcache_resp, e_dresp);
      if (e_iresp) i_exp_q.push_back(bus.pmem_rdata);
      if (e_dresp) d_exp_q.push_back(bus.pmem_rdata);
      if (bus.icache_resp && i_exp_q.size() > 0) chk("icache_rdata", bus.icache_rdata, i_exp_q.pop_front());
      else chk("icache_rdata_gated", bus.icache_rdata, 128'h0);
      if (bus.dcache_resp && d_exp_q.size() > 0) chk("dcache_rdata", bus.dcache_rdata, d_exp_q.pop_front());
      else chk("dcache_rdata_gated", bus.dcache_rdata, 128'h0);
      i_exp_q.delete();
      d_exp_q.delete();
    end
    seen_iresp  = e_iresp && !reset;
    seen_dresp  = e_dresp && !reset;
    seen_strobe = e_rd || e_wr;
  endtask

  task automatic advance_model();
    bit want_i, want_d;
    int pick;
    want_i = bus.icache_read || bus.icache_write;
    want_d = bus.dcache_read || bus.dcache_write;
    if (reset) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (want_i || want_d) begin
        pick    = (want_i && want_d) ? 1 - m_last : (want_d ? 1 : 0);
        m_addr  = pick ? bus.dcache_address : bus.icache_address;
        m_wdata = pick ? bus.dcache_wdata : bus.icache_wdata;
        m_wr    = pick ? bus.dcache_write : bus.icache_write;
        m_last  = pick;
        m_owner = pick;
      end
    end else if (bus.pmem_resp) begin
      m_owner = -1;
    end
  endtask

  // One clock: check on the falling edge, then return 1 time unit after the
  // rising edge so the caller can drive the next cycle's inputs.
  task automatic cycle();
    @(negedge clk);
    compare_model();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_inputs();
    bus.icache_read = 0; bus.icache_write = 0; bus.icache_address = '0; bus.icache_wdata = '0;
    bus.dcache_read = 0; bus.dcache_write = 0; bus.dcache_address = '0; bus.dcache_wdata = '0;
    bus.pmem_resp = 0; bus.pmem_rdata = '0;
  endtask

  initial begin
    logic [127:0] line_a5, line_w;
    line_a5 = {16{8'hA5}};
    line_w  = 128'h0123456789ABCDEF0123456789ABCDEF;
    reset = 1'b1;
    clear_inputs();
    model_reset();
    mem_wait = -1;
    @(posedge clk); #1;
    cycle(); cycle();
    reset = 1'b0;

    // Idle after reset
    repeat (5) cycle();
    #1;
    chk("idle_pmem_read", bus.pmem_read, 0);
    chk("idle_pmem_write", bus.pmem_write, 0);
    chk("idle_pmem_address", bus.pmem_address, 0);
    chk("idle_pmem_wdata", bus.pmem_wdata, 0);
    chk("idle_icache_resp", bus.icache_resp, 0);
    chk("idle_dcache_resp", bus.dcache_resp, 0);

    // I-side read, memory answers three cycles after the strobe
    bus.icache_read = 1; bus.icache_address = 16'h1230;
    cycle(); #1;
    chk("i_read_strobe", bus.pmem_read, 1);
    chk("i_read_addr", bus.pmem_address, 16'h1230);
    cycle(); cycle(); cycle();
    bus.pmem_resp = 1; bus.pmem_rdata = line_a5; bus.icache_read = 0;
    #1;
    chk("i_read_resp", bus.icache_resp, 1);
    chk("i_read_rdata", bus.icache_rdata, line_a5);
    chk("i_read_no_dresp", bus.dcache_resp, 0);
    cycle();
    bus.pmem_resp = 0; #1;
    chk("i_read_idle_after", bus.pmem_read, 0);

    // D-side write
    bus.dcache_write = 1; bus.dcache_address = 16'h4560; bus.dcache_wdata = line_w;
    cycle(); #1;
    chk("d_write_strobe", bus.pmem_write, 1);
    chk("d_write_no_read", bus.pmem_read, 0);
    chk("d_write_wdata", bus.pmem_wdata, line_w);
    cycle();
    bus.pmem_resp = 1; bus.pmem_rdata = rand128(); bus.dcache_write = 0;
    #1;
    chk("d_write_resp", bus.dcache_resp, 1);
    chk("d_write_no_iresp", bus.icache_resp, 0);
    cycle();
    bus.pmem_resp = 0; #1;
    chk("d_write_idle_after", bus.pmem_write, 0);

    // Simultaneous reads after reset: D first, then the tie goes to I
    reset = 1; cycle(); reset = 0;
    bus.icache_read = 1; bus.icache_address = 16'h1000;
    bus.dcache_read = 1; bus.dcache_address = 16'h2000;
    cycle(); #1;
    chk("tie1_addr_d", bus.pmem_address, 16'h2000);
    cycle();
    bus.pmem_resp = 1; bus.pmem_rdata = rand128(); bus.dcache_address = 16'h2040;
    #1;
    chk("tie1_dresp", bus.dcache_resp, 1);
    cycle();
    bus.pmem_resp = 0; #1;
    chk("tie_gap_idle", bus.pmem_read, 0);
    cycle(); #1;
    chk("tie2_addr_i", bus.pmem_address, 16'h1000);
    cycle();
    bus.pmem_resp = 1; bus.pmem_rdata = rand128(); bus.icache_read = 0;
    #1;
    chk("tie2_iresp", bus.icache_resp, 1);
    cycle();
    bus.pmem_resp = 0;
    cycle(); #1;
    chk("tie3_addr_d", bus.pmem_address, 16'h2040);
    cycle();
    bus.pmem_resp = 1; bus.pmem_rdata = rand128(); bus.dcache_read = 0;
    cycle();
    bus.pmem_resp = 0;
    cycle();

    // D address changes mid-transaction, then a stray pmem_resp in IDLE
    bus.dcache_read = 1; bus.dcache_address = 16'h3000;
    cycle();
    bus.dcache_address = 16'h3FF0;
    cycle(); #1;
    chk("d_addr_held", bus.pmem_address, 16'h3000);
    cycle();
    bus.pmem_resp = 1; bus.pmem_rdata = rand128(); bus.dcache_read = 0;
    cycle();
    bus.pmem_resp = 0;
    cycle();
    bus.pmem_resp = 1; bus.pmem_rdata = rand128();
    #1;
    chk("stray_no_iresp", bus.icache_resp, 0);
    chk("stray_no_dresp", bus.dcache_resp, 0);
    cycle();
    bus.pmem_resp = 0;
    cycle();

    // Reset during BUSY_I
    bus.icache_read = 1; bus.icache_address = 16'h5550;
    cycle(); #1;
    chk("rst_busy_strobe", bus.pmem_read, 1);
    reset = 1;
    cycle();
    reset = 0; bus.icache_read = 0; #1;
    chk("rst_strobe_drop", bus.pmem_read, 0);
    cycle();
    bus.pmem_resp = 1; bus.pmem_rdata = rand128();
    #1;
    chk("rst_late_resp", bus.icache_resp, 0);
    cycle();
    clear_inputs();
    cycle();

    // Randomized traffic from both caches against a variable-latency memory
    for (int k = 0; k < 3000; k++) begin
      if (seen_iresp) begin
        bus.icache_read = 0; bus.icache_write = 0;
      end else if (!(bus.icache_read || bus.icache_write) && $urandom_range(0, 2) == 0) begin
        int r = $urandom_range(0, 9);
        bus.icache_read  = (r == 0) || (r > 4);
        bus.icache_write = (r <= 4);
        bus.icache_address = 16'($urandom);
        bus.icache_wdata   = rand128();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.icache_address = 16'($urandom);
      end
      if (seen_dresp) begin
        bus.dcache_read = 0; bus.dcache_write = 0;
      end else if (!(bus.dcache_read || bus.dcache_write) && $urandom_range(0, 2) == 0) begin
        int r = $urandom_range(0, 9);
        bus.dcache_read  = (r == 0) || (r > 4);
        bus.dcache_write = (r <= 4);
        bus.dcache_address = 16'($urandom);
        bus.dcache_wdata   = rand128();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.dcache_wdata = rand128();
      end
      if (reset || bus.pmem_resp) begin
        bus.pmem_resp = 0;
        mem_wait = -1;
      end else if (seen_strobe) begin
        if (mem_wait < 0) mem_wait = $urandom_range(0, 3);
        if (mem_wait == 0) begin
          bus.pmem_resp = 1; bus.pmem_rdata = rand128();
        end else begin
          mem_wait--;
        end
      end else if ($urandom_range(0, 39) == 0) begin
        bus.pmem_resp = 1; bus.pmem_rdata = rand128();
      end
      reset = ($urandom_range(0, 149) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Memory-side responder for the cache line interface: accepts 128-bit line read/write requests from the instruction cache and the data cache and serializes them onto the single physical-memory port. Sits between the two L1 cache datapath/control pairs and physical memory. It answers each cache's line address, write line and read/write strobes with a one-cycle response pulse and read data. Requests from both caches are arbitrated fairly, and each granted transaction is latched so physical memory sees stable signals.

## Interface
- No parameters; widths fixed: address 16 (lc3b_word), line 128 (lc3b_cache_line).
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- icache_read  in  1  I-side line read request, held until icache_resp
- icache_write  in  1  I-side line write request, held until icache_resp
- icache_address  in  16  I-side line address; bits [3:0] passed through unmodified
- icache_wdata  in  128  I-side write line
- icache_rdata  out  128  read line to I-side
- icache_resp  out  1  one-cycle completion pulse to I-side
- dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_rdata, dcache_resp: same as I-side, for D-side
- pmem_read  out  1  physical-memory read strobe
- pmem_write  out  1  physical-memory write strobe
- pmem_address  out  16  latched address of granted request
- pmem_wdata  out  128  latched write line of granted request
- pmem_rdata  in  128  line from physical memory
- pmem_resp  in  1  physical-memory completion, one cycle

## Operation
- States: IDLE, BUSY_I, BUSY_D. Registers: state, last_served (0 = I, 1 = D), req_addr, req_wdata, req_is_write.
- IDLE: port is requesting if read|write asserted.
  - Only I requests -> grant I. Only D requests -> grant D.
  - Both request -> grant the port not equal to last_served.
  - On grant, latch that port's address, wdata, and req_is_write = write. Set last_served to the granted port. Next state is BUSY_I or BUSY_D.
- BUSY_x:
  - pmem_read = ~req_is_write; pmem_write = req_is_write.
  - pmem_address = req_addr; pmem_wdata = req_wdata.
  - Changes on the requester's inputs are ignored while busy.
- Completion: in BUSY_x with pmem_resp = 1:
  - x_resp = 1 combinationally in the same cycle, and x_rdata = pmem_rdata.
  - Next state IDLE.
- Response gating:
  - x_rdata = 0 whenever x_resp = 0.
  - The non-granted port never sees resp.
- Both read and write asserted on one port is a protocol violation. It is resolved as a write (req_is_write = 1).
- pmem_resp while IDLE: ignored, no resp pulsed.
- pmem_read and pmem_write are never both 1.

## Timing
- Reset values:
  - state = IDLE, last_served = I (so the first tie goes to D).
  - req_addr = 0, req_wdata = 0, req_is_write = 0.
  - pmem_read/write = 0, pmem_address = 0, pmem_wdata = 0.
  - icache_resp = dcache_resp = 0, rdata outputs = 0.
- Grant latency:
  - Request present in IDLE at cycle N -> pmem strobe asserted in cycle N+1.
  - Total requester latency = 1 + physical-memory latency cycles.
- Resp is combinational from pmem_resp; it is never registered or delayed.
- The cycle after resp, the arbiter is IDLE.
  - A requester that still shows a request in that cycle is re-granted, so caches must drop the request on seeing resp.
  - A waiting other port is granted in that IDLE cycle: back-to-back service with one idle cycle between pmem transactions.
- Fairness: under continuous requests from both ports, grants strictly alternate.
- Reset mid-transaction:
  - State returns to IDLE and strobes deassert the cycle after reset is sampled.
  - A late pmem_resp is ignored per the IDLE rule.
- Reset has priority over any grant or completion in the same cycle.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0, no pmem strobe.
- I read addr 0x1230, pmem_resp 3 cycles after strobe with rdata = 128'hA5...A5:
  - pmem_read = 1 and pmem_address = 0x1230 from cycle 1.
  - icache_resp pulse with icache_rdata = A5...A5 in the pmem_resp cycle; dcache_resp stays 0.
- D write addr 0x4560, wdata 128'h0123...CDEF:
  - pmem_write = 1, pmem_wdata matches, pmem_read = 0.
  - dcache_resp on pmem_resp; IDLE next cycle.
- Both ports request reads simultaneously after reset:
  - D granted first; I granted in the IDLE cycle after D's resp.
  - With requests reasserted, the next tie goes to I.
- D requester changes address mid-transaction:
  - pmem_address stays at the latched value until resp.
  - Stray pmem_resp in IDLE -> no resp on either port.
- Reset asserted during BUSY_I before pmem_resp:
  - pmem_read = 0 the next cycle.
  - A following pmem_resp produces no icache_resp.
